fifo_write_arbiter: RTL and testbench

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

---
 rtl/fifo_write_arbiter.sv | 107 ++++++++++
 tb/tb_fifo_write_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// ============================================================================
// Module  : fifo_write_arbiter
// Brief   : Round-robin arbiter granting bursts of beats into a shared FIFO.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       fifo_full,
  output logic                       fifo_write_en,
  output logic [WIDTH-1:0]           fifo_data_in,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [15:0]                stall_cnt
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int BEAT_W = 5;

  localparam logic [0:0] c_IDLE  = 1'b0;
  localparam logic [0:0] c_GRANT = 1'b1;

  logic [0:0]        r_state;
  logic [ID_W-1:0]   r_grant_id;
  logic [ID_W-1:0]   r_last_grant;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic [15:0]       r_stall_cnt;

  logic              w_owner_valid;
  logic              w_transfer;
  logic              w_found;
  logic [ID_W-1:0]   w_winner;
  int                w_idx;

  assign w_owner_valid = req_valid[r_grant_id];
  assign w_transfer    = (r_state == c_GRANT) && w_owner_valid && !fifo_full;

  assign grant_valid   = (r_state == c_GRANT);
  assign grant_id      = r_grant_id;
  assign stall_cnt     = r_stall_cnt;
  assign fifo_write_en = w_transfer;
  assign fifo_data_in  = w_transfer ? req_data[r_grant_id*WIDTH +: WIDTH] : '0;
  assign req_ready     = w_transfer ? (NUM_REQ'(1) << r_grant_id) : '0;

  // Search starts just after the previous owner and wraps around once.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx = int'(r_last_grant) + i;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!w_found && req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = ID_W'(w_idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_IDLE;
      r_grant_id   <= '0;
      r_last_grant <= ID_W'(NUM_REQ-1);
      r_beat_cnt   <= '0;
      r_stall_cnt  <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_found && !fifo_full) begin
            r_state    <= c_GRANT;
            r_grant_id <= w_winner;
            r_beat_cnt <= '0;
          end
        end
        c_GRANT: begin
          if (!w_owner_valid) begin
            r_state      <= c_IDLE;
            r_last_grant <= r_grant_id;
          end else if (!fifo_full) begin
            r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
            if (r_beat_cnt == BEAT_W'(MAX_BURST-1)) begin
              r_state      <= c_IDLE;
              r_last_grant <= r_grant_id;
            end
          end else if (r_stall_cnt != 16'hFFFF) begin
            // Owner is blocked by a full FIFO: keep the grant, count the stall.
            r_stall_cnt <= r_stall_cnt + 16'd1;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
// ============================================================================
// Module  : tb_fifo_write_arbiter
// Brief   : Directed self-checking bench for fifo_write_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_write_en;
  logic [7:0]  fifo_data_in;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic [15:0] stall_cnt;

  int n_tests;
  int n_fail;
  int n_writes;

  fifo_write_arbiter #(.NUM_REQ(4), .WIDTH(8), .MAX_BURST(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .fifo_full     (fifo_full),
    .fifo_write_en (fifo_write_en),
    .fifo_data_in  (fifo_data_in),
    .grant_valid   (grant_valid),
    .grant_id      (grant_id),
    .stall_cnt     (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge; inputs change here, outputs are checked #1 later.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_write(input string tag, input logic [1:0] id, input logic [7:0] data);
    #1;
    check({tag, "_gv"},   32'(grant_valid),   32'd1);
    check({tag, "_gid"},  32'(grant_id),      32'(id));
    check({tag, "_we"},   32'(fifo_write_en), 32'd1);
    check({tag, "_data"}, 32'(fifo_data_in),  32'(data));
    check({tag, "_rdy"},  32'(req_ready),     32'(4'b0001 << id));
  endtask

  task automatic check_idle(input string tag);
    #1;
    check({tag, "_gv"},   32'(grant_valid),   32'd0);
    check({tag, "_we"},   32'(fifo_write_en), 32'd0);
    check({tag, "_data"}, 32'(fifo_data_in),  32'd0);
    check({tag, "_rdy"},  32'(req_ready),     32'd0);
  endtask

  // Reset is held across one falling edge, then released away from the rising edge.
  task automatic apply_reset();
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("rst_gv",    32'(grant_valid), 32'd0);
    check("rst_gid",   32'(grant_id),    32'd0);
    check("rst_stall", 32'(stall_cnt),   32'd0);
    check("rst_we",    32'(fifo_write_en), 32'd0);
    check("rst_rdy",   32'(req_ready),   32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] order [5];
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    fifo_full = 1'b0;
    req_valid = 4'b0000;
    req_data  = 32'h0;

    // All four requesters valid: 0,1,2,3,0, four beats each, one idle cycle between.
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    req_valid = 4'b1111;
    req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    apply_reset();
    n_writes = 0;
    for (int g = 0; g < 5; g++) begin
      check_idle("rr_idle");
      for (int b = 0; b < 4; b++) begin
        tick();
        check_write("rr_beat", order[g], 8'hA0 + 8'(order[g]));
        if (fifo_write_en) n_writes++;
      end
      tick();
    end
    check("rr_duty", 32'(n_writes), 32'd20);

    // Only requester 2, dropping valid after two beats.
    req_valid = 4'b0100;
    apply_reset();
    check_idle("r2_idle0");
    tick(); check_write("r2_b0", 2'd2, 8'hA2);
    tick(); check_write("r2_b1", 2'd2, 8'hA2);
    tick(); req_valid = 4'b0000;
    #1;
    check("r2_drop_gv", 32'(grant_valid),   32'd1);
    check("r2_drop_we", 32'(fifo_write_en), 32'd0);
    tick(); check_idle("r2_idle1");
    req_valid = 4'b0101;
    tick(); check_write("r2_next", 2'd0, 8'hA0);

    // FIFO full for three cycles in the middle of requester 1's burst.
    req_valid = 4'b0010;
    apply_reset();
    tick(); check_write("st_b0", 2'd1, 8'hA1);
    tick(); check_write("st_b1", 2'd1, 8'hA1);
    for (int s = 0; s < 3; s++) begin
      tick(); fifo_full = 1'b1;
      #1;
      check("st_gv",   32'(grant_valid),   32'd1);
      check("st_gid",  32'(grant_id),      32'd1);
      check("st_we",   32'(fifo_write_en), 32'd0);
      check("st_data", 32'(fifo_data_in),  32'd0);
      check("st_rdy",  32'(req_ready),     32'd0);
    end
    tick(); fifo_full = 1'b0;
    check_write("st_b2", 2'd1, 8'hA1);
    check("st_cnt", 32'(stall_cnt), 32'd3);
    tick(); check_write("st_b3", 2'd1, 8'hA1);
    tick(); check_idle("st_end");
    check("st_cnt_hold", 32'(stall_cnt), 32'd3);

    // FIFO full while idle: no grant until it clears.
    req_valid = 4'b1111;
    fifo_full = 1'b1;
    apply_reset();
    for (int s = 0; s < 3; s++) begin
      tick(); check_idle("fi_hold");
    end
    fifo_full = 1'b0;
    check_idle("fi_arb");
    tick(); check_write("fi_grant", 2'd0, 8'hA0);

    // Asynchronous reset mid-burst of requester 3.
    req_valid = 4'b1000;
    apply_reset();
    tick(); check_write("ar_b0", 2'd3, 8'hA3);
    tick(); check_write("ar_b1", 2'd3, 8'hA3);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_gv",   32'(grant_valid),   32'd0);
    check("ar_gid",  32'(grant_id),      32'd0);
    check("ar_we",   32'(fifo_write_en), 32'd0);
    check("ar_data", 32'(fifo_data_in),  32'd0);
    check("ar_rdy",  32'(req_ready),     32'd0);
    req_valid = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    tick(); check_write("ar_first", 2'd0, 8'hA0);

    // Requester 1 changes data every beat while non-owners toggle theirs.
    req_valid = 4'b0010;
    req_data  = {8'h00, 8'h00, 8'h10, 8'h00};
    apply_reset();
    for (int b = 0; b < 4; b++) begin
      tick();
      req_data[15:8]  = 8'h10 + 8'(b);
      req_data[7:0]   = 8'($urandom);
      req_data[31:24] = 8'($urandom);
      check_write("dt_beat", 2'd1, 8'h10 + 8'(b));
      #1 req_data[7:0] = ~req_data[7:0];
      req_data[31:24]  = ~req_data[31:24];
      #1 check("dt_nonowner", 32'(fifo_data_in), 32'(8'h10 + 8'(b)));
    end
    tick(); check_idle("dt_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
